// File: rtl/xdma_rd_port_arbiter.sv
// Shares one AXI4 read master (AR + R) between NUM_REQ read masters, several bursts in flight.
// AR: request accepted in cycle N, m_arvalid in N+1; R: zero-latency combinational routing.
// Backpressure: AR stalls in HOLD until m_arready and grants stop at MAX_OUTSTANDING; R follows s_rready[head].
//
// Ports:
//   data_clk, data_rst_n          clock, asynchronous active-low reset
//   s_ar*  (per requester)        arvalid/arready, araddr packed at [i*ADDR_W +: ADDR_W], arlen at [i*8 +: 8]
//   s_r*                          rvalid/rready per requester; rdata/rlast shared, qualified by s_rvalid[i]
//   m_ar*, m_r*                   single AXI4 read master port toward memory
//   outstanding                   bursts issued on the master port and not yet completed
// Configuration macro: RDARB_FIXED_PRIO_EN (defined: lowest index wins; undefined: round-robin).

module xdma_rd_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                data_clk,
  input  logic                                data_rst_n,
  input  logic [NUM_REQ-1:0]                  s_arvalid,
  output logic [NUM_REQ-1:0]                  s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]           s_araddr,
  input  logic [NUM_REQ*8-1:0]                s_arlen,
  output logic [NUM_REQ-1:0]                  s_rvalid,
  input  logic [NUM_REQ-1:0]                  s_rready,
  output logic [DATA_W-1:0]                   s_rdata,
  output logic                                s_rlast,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [ADDR_W-1:0]                   m_araddr,
  output logic [7:0]                          m_arlen,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [DATA_W-1:0]                   m_rdata,
  input  logic                                m_rlast,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            arb_en;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   gnt_q;
  logic            grant;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [GW-1:0]   head;
  logic [GW-1:0]   order_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // Requester selection. Only meaningful when some s_arvalid is set.
`ifdef RDARB_FIXED_PRIO_EN
  always_comb begin
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_arvalid[k]) gnt_idx = GW'(k);
    end
  end
`else
  // rr_ptr is the first index scanned, i.e. one past the last grant.
  logic [GW-1:0] rr_ptr;

  always_comb begin
    logic hit;
    int   idx;
    hit     = 1'b0;
    idx     = 0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!hit && s_arvalid[idx]) begin
        hit     = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // The occupancy check uses the registered count: a pop in the same cycle
  // does not free a slot until the next cycle.
  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  always_comb begin
    state_d   = state_q;
    s_arready = '0;
    grant     = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && (|s_arvalid) && !full) begin
          grant              = 1'b1;
          s_arready[gnt_idx] = 1'b1;
          state_d            = HOLD;
        end
      end
      HOLD: begin
        if (m_arready) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_arvalid = (state_q == HOLD);

  // arb_en holds off grants until the first clock after reset release, so
  // s_arready stays low while reset is asserted.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      arb_en   <= 1'b0;
      state_q  <= IDLE;
      m_araddr <= '0;
      m_arlen  <= '0;
      gnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      arb_en  <= 1'b1;
      state_q <= state_d;
      if (grant) begin
        m_araddr <= s_araddr[gnt_idx*ADDR_W +: ADDR_W];
        m_arlen  <= s_arlen[gnt_idx*8 +: 8];
        gnt_q    <= gnt_idx;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Order FIFO storage: occupancy is tracked by count, so no reset needed.
  always_ff @(posedge data_clk) begin
    if (push) order_mem[wr_ptr] <= gnt_q;
  end

  assign head        = order_mem[rd_ptr];
  assign pop         = m_rvalid & m_rready & m_rlast;
  assign m_rready    = !empty && s_rready[head];
  assign s_rdata     = m_rdata;
  assign s_rlast     = m_rlast;
  assign outstanding = count;

  always_comb begin
    s_rvalid = '0;
    if (m_rvalid && !empty) s_rvalid[head] = 1'b1;
  end

endmodule

// File: tb/tb_xdma_rd_port_arbiter.sv
module tb_xdma_rd_port_arbiter;

  localparam int N    = 2;
  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    s_arvalid = '0, s_arready, s_rvalid, s_rready = '0;
  logic [N*AW-1:0] s_araddr = '0;
  logic [N*8-1:0]  s_arlen = '0;
  logic [DW-1:0]   s_rdata, m_rdata = '0;
  logic            s_rlast, m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready, m_rlast = 1'b0;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [3:0]      outstanding;

  always #5 clk = ~clk;

  xdma_rd_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .data_clk(clk), .data_rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .outstanding(outstanding)
  );

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } req_t;

  int n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  req_t req_q  [N][$];   // pending requests per requester
  req_t exp_r  [N][$];   // accepted bursts per requester, awaiting data
  int   exp_beat [N];
  req_t mem_q [$];       // bursts accepted by memory
  int   mem_beat;
  int   issue_q [$];     // requester of each burst in flight, issue order
  int   mcnt;
  bit   hold_busy;
  req_t hold_req;
  int   hold_g;
  int   rr_ptr;
  bit   rv_pend;
  int   grant_log [$];
  int   route_log [$];

  // stimulus knobs
  bit   rvalid_en = 1'b1;
  int   rvalid_pct = 100;
  int   arready_mode = 1;   // 0 random, 1 always
  int   rready_mode = 2;    // 0 random, 1 toggle, 2 always
  bit   stray = 1'b0;
  bit   tog = 1'b0;

  function automatic req_t mk_req(logic [63:0] a, logic [7:0] l);
    req_t r;
    r.addr = a;
    r.len  = l;
    return r;
  endfunction

  function automatic logic [31:0] beat_data(logic [63:0] a, int b);
    return a[31:0] + 32'(b) * 32'h0101_0001;
  endfunction

  function automatic int pick(logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
`ifdef RDARB_FIXED_PRIO_EN
      if (v[k]) return k;
`else
      if (v[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
`endif
    end
    return 0;
  endfunction

  function automatic bit quiet();
    return !hold_busy && mcnt == 0 && req_q[0].size() == 0 && req_q[1].size() == 0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      req_q[i].delete();
      exp_r[i].delete();
      exp_beat[i] = 0;
    end
    mem_q.delete();
    issue_q.delete();
    grant_log.delete();
    route_log.delete();
    mem_beat = 0; mcnt = 0; hold_busy = 0; hold_g = 0; rr_ptr = 0; rv_pend = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_arvalid[i] = rst_n && req_q[i].size() > 0;
      if (s_arvalid[i]) begin
        s_araddr[i*AW +: AW] = req_q[i][0].addr;
        s_arlen[i*8 +: 8]    = req_q[i][0].len;
      end
    end
    tog = ~tog;
    case (rready_mode)
      0:       for (int i = 0; i < N; i++) s_rready[i] = ($urandom_range(0, 3) != 0);
      1:       s_rready = {N{tog}};
      default: s_rready = '1;
    endcase
    m_arready = (arready_mode == 1) ? 1'b1 : 1'(($urandom_range(0, 1)));
    if (!rst_n) begin
      m_rvalid = 1'b0;
    end else if (stray) begin
      m_rvalid = 1'b1; m_rdata = 32'hdead_beef; m_rlast = 1'b1;
    end else begin
      m_rvalid = (rv_pend || (rvalid_en && ($urandom_range(0, 99) < rvalid_pct))) && mem_q.size() > 0;
      if (mem_q.size() > 0) begin
        m_rdata = beat_data(mem_q[0].addr, mem_beat);
        m_rlast = (mem_beat == int'(mem_q[0].len));
      end
    end
  endtask

  task automatic check_and_update();
    bit gexp;
    int head, g;
    logic [N-1:0] hs;
    gexp = !hold_busy && (s_arvalid != '0) && mcnt < MAXO;
    head = (issue_q.size() > 0) ? issue_q[0] : 0;
    chk("outstanding", 64'(outstanding), 64'(mcnt));
    chk("m_arvalid", 64'(m_arvalid), 64'(hold_busy));
    if (hold_busy) begin
      chk("m_araddr", m_araddr, hold_req.addr);
      chk("m_arlen", 64'(m_arlen), 64'(hold_req.len));
    end
    chk("s_arready", 64'(s_arready), gexp ? (64'(1) << pick(s_arvalid)) : 64'(0));
    chk("s_rvalid", 64'(s_rvalid), (m_rvalid && issue_q.size() > 0) ? (64'(1) << head) : 64'(0));
    chk("m_rready", 64'(m_rready), 64'(issue_q.size() > 0 && s_rready[head]));
    // R beat handshake
    if (m_rvalid && m_rready && !stray && issue_q.size() > 0 && exp_r[head].size() > 0) begin
      chk("r_data", 64'(s_rdata), 64'(beat_data(exp_r[head][0].addr, exp_beat[head])));
      chk("r_last", 64'(s_rlast), 64'(exp_beat[head] == int'(exp_r[head][0].len)));
      route_log.push_back(head);
      if (m_rlast) begin
        void'(exp_r[head].pop_front());
        exp_beat[head] = 0;
        void'(issue_q.pop_front());
        if (mem_q.size() > 0) void'(mem_q.pop_front());
        mem_beat = 0;
        mcnt--;
      end else begin
        exp_beat[head]++;
        mem_beat++;
      end
    end
    rv_pend = m_rvalid && !m_rready && !stray;
    // AR master handshake (uses the burst registered before this cycle)
    if (m_arvalid && m_arready) begin
      mem_q.push_back(mk_req(m_araddr, m_arlen));
      issue_q.push_back(hold_g);
      mcnt++;
      hold_busy = 0;
    end
    // AR requester handshake
    hs = s_arvalid & s_arready;
    if (hs != '0) begin
      g = 0;
      for (int i = N - 1; i >= 0; i--) if (hs[i]) g = i;
      hold_busy = 1;
      hold_g    = g;
      hold_req  = req_q[g][0];
      exp_r[g].push_back(req_q[g][0]);
      void'(req_q[g].pop_front());
      rr_ptr = (g + 1) % N;
      grant_log.push_back(g);
    end
  endtask

  // Per-cycle driver/checker: drive at +1, sample and update at +2.
  initial begin : mon
    clear_model();
    forever begin
      @(posedge clk);
      #1;
      drive();
      #1;
      if (rst_n) check_and_update();
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst_s_arready", 64'(s_arready), 64'(0));
    chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
    chk("rst_m_rready", 64'(m_rready), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_m_araddr", m_araddr, 64'(0));
    chk("rst_m_arlen", 64'(m_arlen), 64'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_quiet(string tag, int budget);
    int k;
    k = 0;
    while (k < budget && !quiet()) begin
      @(posedge clk);
      k++;
    end
    chk(tag, 64'(quiet()), 64'(1));
    @(posedge clk);
    #3;
  endtask

  task automatic wait_grants(string tag, int n, int budget);
    int k;
    k = 0;
    while (k < budget && grant_log.size() < n) begin
      @(posedge clk);
      k++;
    end
    chk(tag, 64'(grant_log.size() >= n), 64'(1));
  endtask

  task automatic set_knobs(bit rv_en, int pct, int arm, int rrm);
    rvalid_en = rv_en; rvalid_pct = pct; arready_mode = arm; rready_mode = rrm;
  endtask

  int exp_t2 [4];
  int exp_t4 [6] = '{0, 0, 1, 0, 0, 0};
  int k6, r;

  initial begin : stim
`ifdef RDARB_FIXED_PRIO_EN
    exp_t2 = '{0, 0, 0, 0};
`else
    exp_t2 = '{0, 1, 0, 1};
`endif
    // T1: single request
    set_knobs(1, 100, 1, 2);
    do_reset();
    req_q[1].push_back(mk_req(64'h1000, 8'd3));
    wait_quiet("t1_done", 100);
    chk("t1_beats", 64'(route_log.size()), 64'(4));
    for (int i = 0; i < route_log.size(); i++) chk("t1_route", 64'(route_log[i]), 64'(1));

    // T2: contention
    set_knobs(0, 100, 1, 2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_q[0].push_back(mk_req(64'h2000 + 64'(i * 64), 8'd1));
      req_q[1].push_back(mk_req(64'h3000 + 64'(i * 64), 8'd2));
    end
    wait_grants("t2_grants", 4, 100);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_order", 64'(grant_log[i]), 64'(exp_t2[i]));
    rvalid_en = 1;
    wait_quiet("t2_done", 400);

    // T3: full
    set_knobs(0, 100, 1, 2);
    do_reset();
    for (int i = 0; i < 9; i++) req_q[i % 2].push_back(mk_req(64'h4000 + 64'(i * 256), 8'(i % 3)));
    repeat (40) @(posedge clk);
    #3;
    chk("t3_full_cnt", 64'(outstanding), 64'(MAXO));
    chk("t3_pending", 64'(req_q[0].size() + req_q[1].size()), 64'(1));
    chk("t3_no_ready", 64'(s_arready), 64'(0));
    rvalid_en = 1;
    wait_quiet("t3_done", 400);

    // T4: interleaved return
    set_knobs(1, 100, 1, 2);
    do_reset();
    req_q[0].push_back(mk_req(64'h5000, 8'd1));
    wait_grants("t4_g1", 1, 50);
    req_q[1].push_back(mk_req(64'h5100, 8'd0));
    wait_grants("t4_g2", 2, 50);
    req_q[0].push_back(mk_req(64'h5200, 8'd2));
    wait_quiet("t4_done", 200);
    chk("t4_beats", 64'(route_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < route_log.size(); i++) chk("t4_route", 64'(route_log[i]), 64'(exp_t4[i]));

    // T5: toggling backpressure on a 16-beat burst
    set_knobs(1, 100, 1, 1);
    do_reset();
    req_q[1].push_back(mk_req(64'h6000, 8'd15));
    wait_quiet("t5_done", 200);
    chk("t5_beats", 64'(route_log.size()), 64'(16));

    // Stray m_rvalid with nothing outstanding must stall
    set_knobs(1, 100, 1, 2);
    stray = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("stray_rready", 64'(m_rready), 64'(0));
    chk("stray_rvalid", 64'(s_rvalid), 64'(0));
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #3;

    // T6: reset mid-burst, then normal operation
    do_reset();
    req_q[0].push_back(mk_req(64'h7000, 8'd7));
    k6 = 0;
    while (k6 < 100 && route_log.size() < 2) begin
      @(posedge clk);
      k6++;
    end
    chk("t6_started", 64'(route_log.size() >= 2), 64'(1));
    do_reset();
    chk("t6_cnt_after", 64'(outstanding), 64'(0));
    req_q[1].push_back(mk_req(64'h7100, 8'd2));
    wait_quiet("t6_done", 100);
    chk("t6_beats", 64'(route_log.size()), 64'(3));

    // Random traffic
    set_knobs(1, 60, 0, 0);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, N - 1));
        if (req_q[r].size() < 3)
          req_q[r].push_back(mk_req({32'h0, $urandom()}, 8'($urandom_range(0, 5))));
      end
    end
    wait_quiet("rand_done", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
